obstacle_scheduler: RTL and testbench

OBSTACLE_SCHEDULER -- requirements
Module: obstacle_scheduler

---
 rtl/obstacle_scheduler_if.sv | 21 ++
 rtl/obstacle_scheduler.sv | 104 ++++++++++
 tb/tb_obstacle_scheduler.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/obstacle_scheduler_if.sv
// Signal bundle between the obstacle scheduler, the game controller, the LFSR and the obstacle datapath.
interface obstacle_scheduler_if;
  logic       game_active;
  logic       frame_tick;
  logic [7:0] lfsr_data;
  logic       lfsr_enable;
  logic       spawn_valid;
  logic       spawn_ready;
  logic [1:0] spawn_type;
  logic [1:0] level;

  modport master (
    input  game_active, frame_tick, lfsr_data, spawn_ready,
    output lfsr_enable, spawn_valid, spawn_type, level
  );

  modport slave (
    output game_active, frame_tick, lfsr_data, spawn_ready,
    input  lfsr_enable, spawn_valid, spawn_type, level
  );
endinterface

// File: rtl/obstacle_scheduler.sv
// Schedules obstacle spawns with a random frame gap that shrinks as the difficulty level rises.
// Optional macro DINO_BIRD_SPAWN_EN allows bird obstacles (spawn_type 3).
module obstacle_scheduler #(
  parameter int MIN_GAP      = 24,
  parameter int LEVEL_SPAWNS = 8
) (
  input  logic clk,
  input  logic rst,
  obstacle_scheduler_if.master bus
);

  typedef enum logic [1:0] {IDLE, WAIT_GAP, DRAW, OFFER} state_t;

  localparam logic [7:0] MIN_GAP_8  = 8'(MIN_GAP);
  localparam logic [7:0] LAST_SPAWN = 8'(LEVEL_SPAWNS - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] gap_cnt;
  logic [7:0] next_gap;
  logic [7:0] spawn_cnt;
  logic [1:0] spawn_type_r;
  logic [1:0] level_r;
  logic [4:0] draw_offset;
  logic [7:0] draw_gap;
  logic [1:0] draw_type;
  logic       abort;

  assign abort       = (state != IDLE) && !bus.game_active;
  assign draw_offset = bus.lfsr_data[7:3] >> level_r;
  assign draw_gap    = MIN_GAP_8 + {3'b000, draw_offset};

`ifdef DINO_BIRD_SPAWN_EN
  assign draw_type = bus.lfsr_data[1:0];
`else
  assign draw_type = (bus.lfsr_data[1:0] == 2'd3) ? 2'd0 : bus.lfsr_data[1:0];
`endif

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (bus.game_active) state_next = WAIT_GAP;
      WAIT_GAP: begin
        if (!bus.game_active)
          state_next = IDLE;
        // Leave as the counter reaches zero so DRAW follows the final tick directly
        else if ((gap_cnt == 8'd0) || (bus.frame_tick && (gap_cnt == 8'd1)))
          state_next = DRAW;
      end
      DRAW:     state_next = bus.game_active ? OFFER : IDLE;
      OFFER: begin
        if (!bus.game_active)
          state_next = IDLE;
        else if (bus.spawn_ready)
          state_next = WAIT_GAP;
      end
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      gap_cnt      <= 8'd0;
      next_gap     <= MIN_GAP_8;
      spawn_cnt    <= 8'd0;
      spawn_type_r <= 2'd0;
      level_r      <= 2'd0;
    end else begin
      state <= state_next;
      if (abort) begin
        spawn_cnt <= 8'd0;
        level_r   <= 2'd0;
      end else begin
        unique case (state)
          IDLE:     if (bus.game_active) gap_cnt <= MIN_GAP_8;
          WAIT_GAP: if (bus.frame_tick && (gap_cnt != 8'd0)) gap_cnt <= gap_cnt - 8'd1;
          DRAW: begin
            spawn_type_r <= draw_type;
            next_gap     <= draw_gap;
          end
          OFFER: begin
            if (bus.spawn_ready) begin
              gap_cnt <= next_gap;
              if (spawn_cnt == LAST_SPAWN) begin
                spawn_cnt <= 8'd0;
                if (level_r != 2'd3) level_r <= level_r + 2'd1;
              end else begin
                spawn_cnt <= spawn_cnt + 8'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.lfsr_enable = (state != IDLE);
  assign bus.spawn_valid = (state == OFFER);
  assign bus.spawn_type  = spawn_type_r;
  assign bus.level       = level_r;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed bench for obstacle_scheduler: gap timing checked inline, spawned obstacles checked by a scoreboard.
module tb_obstacle_scheduler;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  obstacle_scheduler_if bus ();

  obstacle_scheduler #(.MIN_GAP(24), .LEVEL_SPAWNS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef DINO_BIRD_SPAWN_EN
  localparam int BIRD_TYPE = 3;
`else
  localparam int BIRD_TYPE = 0;
`endif

  int total = 0;
  int bad   = 0;
  int exp_type_q[$];
  int exp_level_q[$];

  task automatic check_output(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: every accepted spawn must match the oldest expected entry
  always @(negedge clk) begin
    if (bus.spawn_valid && bus.spawn_ready) begin
      if (exp_type_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_spawn: got type %0d, expected no spawn", bus.spawn_type);
      end else begin
        check_output("spawn_type", int'(bus.spawn_type), exp_type_q.pop_front());
        check_output("spawn_level", int'(bus.level), exp_level_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_once();
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    step();
  endtask

  task automatic run_gap(input int gap);
    for (int k = 1; k < gap; k++) tick_once();
    check_output("no_early_offer", int'(bus.spawn_valid), 0);
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    check_output("draw_cycle_no_valid", int'(bus.spawn_valid), 0);
    step();
    check_output("offer_valid", int'(bus.spawn_valid), 1);
  endtask

  task automatic handshake(input int exp_type, input int exp_level, input logic load_tick);
    exp_type_q.push_back(exp_type);
    exp_level_q.push_back(exp_level);
    bus.spawn_ready = 1'b1;
    bus.frame_tick  = load_tick;
    step();
    bus.spawn_ready = 1'b0;
    bus.frame_tick  = 1'b0;
    check_output("post_handshake_valid", int'(bus.spawn_valid), 0);
  endtask

  task automatic apply_stimulus(input int gap, input logic [7:0] data, input int exp_type,
                                input int exp_level, input logic stall);
    bus.lfsr_data = data;
    run_gap(gap);
    if (stall) begin
      for (int c = 0; c < 10; c++) begin
        bus.frame_tick = (c == 2 || c == 5 || c == 8);
        step();
        check_output("stall_valid", int'(bus.spawn_valid), 1);
        check_output("stall_type", int'(bus.spawn_type), exp_type);
      end
      bus.frame_tick = 1'b0;
    end
    handshake(exp_type, exp_level, stall);
  endtask

  initial begin
    rst             = 1'b1;
    bus.game_active = 1'b0;
    bus.frame_tick  = 1'b0;
    bus.lfsr_data   = 8'h00;
    bus.spawn_ready = 1'b0;
    step();
    step();
    check_output("reset_lfsr_enable", int'(bus.lfsr_enable), 0);
    check_output("reset_spawn_valid", int'(bus.spawn_valid), 0);
    check_output("reset_spawn_type", int'(bus.spawn_type), 0);
    check_output("reset_level", int'(bus.level), 0);

    rst = 1'b0;
    step();
    check_output("idle_hold_lfsr_enable", int'(bus.lfsr_enable), 0);

    // Start with a tick in the load cycle, which must not shorten the first gap
    bus.game_active = 1'b1;
    bus.frame_tick  = 1'b1;
    step();
    bus.frame_tick  = 1'b0;
    check_output("start_lfsr_enable", int'(bus.lfsr_enable), 1);

    apply_stimulus(24, 8'hF8, 0, 0, 1'b1);
    apply_stimulus(55, 8'h03, BIRD_TYPE, 0, 1'b0);
    apply_stimulus(24, 8'h09, 1, 0, 1'b0);
    apply_stimulus(25, 8'h02, 2, 0, 1'b0);
    for (int i = 5; i <= 7; i++) apply_stimulus(24, 8'h02, 2, 0, 1'b0);
    apply_stimulus(24, 8'hF8, 0, 0, 1'b0);
    check_output("level_after_8", int'(bus.level), 1);

    apply_stimulus(55, 8'hF8, 0, 1, 1'b0);
    apply_stimulus(39, 8'h02, 2, 1, 1'b0);
    for (int i = 11; i <= 16; i++) apply_stimulus(24, 8'h02, 2, 1, 1'b0);
    check_output("level_after_16", int'(bus.level), 2);

    apply_stimulus(24, 8'hF8, 0, 2, 1'b0);
    apply_stimulus(31, 8'h02, 2, 2, 1'b0);
    for (int i = 19; i <= 24; i++) apply_stimulus(24, 8'h02, 2, 2, 1'b0);
    check_output("level_after_24", int'(bus.level), 3);

    apply_stimulus(24, 8'hF8, 0, 3, 1'b0);
    apply_stimulus(27, 8'h02, 2, 3, 1'b0);
    check_output("level_saturated", int'(bus.level), 3);

    // Abort coinciding with a handshake: transfer counts, then everything clears
    bus.lfsr_data = 8'h02;
    run_gap(24);
    exp_type_q.push_back(2);
    exp_level_q.push_back(3);
    bus.game_active = 1'b0;
    bus.spawn_ready = 1'b1;
    step();
    bus.spawn_ready = 1'b0;
    check_output("abort_spawn_valid", int'(bus.spawn_valid), 0);
    check_output("abort_lfsr_enable", int'(bus.lfsr_enable), 0);
    check_output("abort_level", int'(bus.level), 0);

    bus.game_active = 1'b1;
    step();
    check_output("restart_lfsr_enable", int'(bus.lfsr_enable), 1);
    apply_stimulus(24, 8'h51, 1, 0, 1'b0);

    // Reset in the middle of a 34-frame gap once the counter reads 10
    for (int k = 0; k < 24; k++) tick_once();
    rst = 1'b1;
    step();
    check_output("midgap_rst_lfsr_enable", int'(bus.lfsr_enable), 0);
    check_output("midgap_rst_spawn_valid", int'(bus.spawn_valid), 0);
    check_output("midgap_rst_spawn_type", int'(bus.spawn_type), 0);
    check_output("midgap_rst_level", int'(bus.level), 0);
    rst = 1'b0;
    step();
    check_output("post_rst_lfsr_enable", int'(bus.lfsr_enable), 1);
    apply_stimulus(24, 8'hF8, 0, 0, 1'b0);

    step();
    step();
    check_output("scoreboard_drained", exp_type_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
